// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl: syncs ext_int, merges timer_int into interrupt_flag, raises int_req/int_ipnum with post-ack holdoff; define CP0_INT_EDGE_EN for sticky edge-triggered HW lines
module cp0_int_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ext_int,
  input  logic        timer_int,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic        int_ack,
  output logic [7:0]  interrupt_flag,
  output logic        int_req,
  output logic [2:0]  int_ipnum
);
  logic [5:0] sync_q [SYNC_STAGES];
  logic [5:0] s;
  logic [5:0] h;
  logic [7:0] p;
  logic       en;
  logic [2:0] ipnum_nxt;
  logic [3:0] hold_cnt;
  logic       unused_bits;
  assign unused_bits = ^{cp0_status[31:16], cp0_status[7:3], cp0_cause[31:16], cp0_cause[7:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ext_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign s = sync_q[SYNC_STAGES-1];
`ifdef CP0_INT_EDGE_EN
  logic [5:0] s_d;
  logic [5:0] pend;
  logic [5:0] clr;
  assign clr = (int_ack && int_ipnum >= 3'd2) ? 6'd1 << (int_ipnum - 3'd2) : 6'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      s_d  <= '0;
      pend <= '0;
    end else begin
      s_d  <= s;
      pend <= (pend & ~clr) | (s & ~s_d);
    end
  end
  assign h = pend;
`else
  assign h = s;
`endif
  assign en = cp0_status[0] & ~cp0_status[1] & ~cp0_status[2];
  assign p  = cp0_status[15:8] & cp0_cause[15:8];
  always_comb begin
    ipnum_nxt = '0;
    for (int i = 1; i < 8; i++) ipnum_nxt = p[i] ? 3'(i) : ipnum_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      interrupt_flag <= '0;
      int_req        <= 1'b0;
      int_ipnum      <= '0;
      hold_cnt       <= '0;
    end else begin
      interrupt_flag <= {h[5] | timer_int, h[4:0], 2'b00};
      int_req        <= en & (|p) & (hold_cnt == 4'd0) & ~int_ack;
      int_ipnum      <= ipnum_nxt;
      hold_cnt       <= int_ack ? 4'(HOLDOFF_CYCLES) : (hold_cnt != 4'd0) ? hold_cnt - 4'd1 : 4'd0;
    end
  end
endmodule
